// File: rtl/x_mem_rv32i.sv
// Word memory serving the rv32i core bus with programmable wait states.
// It also has a side load port and sticky address and protocol error flags.
module x_mem_rv32i #(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_rnw,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic        o_accept,
    output logic [31:0] o_data,
    input  logic        i_ld_valid,
    input  logic [31:0] i_ld_addr,
    input  logic [31:0] i_ld_data,
    output logic        o_ld_ready,
    output logic        o_addr_err,
    output logic        o_proto_err,
    output logic [1:0]  o_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    // Bus handshake: the core raises i_valid with a stable rnw/addr/data and holds
    // it until o_accept; o_accept is a single-cycle strobe and never repeats back-to-back.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_rnw;
    logic [31:0] cap_addr;
    logic [31:0] cap_data;
    logic [31:0] mem [DEPTH];

    logic        ld_in_range;
    logic        bus_in_range;
    logic        cap_in_range;
    logic        ld_we;
    logic        bus_we;
    logic        req_changed;
    logic        unused_bits;

    assign ld_in_range  = (i_ld_addr[31:AW+2] == '0);
    assign bus_in_range = (i_addr[31:AW+2] == '0);
    assign cap_in_range = (cap_addr[31:AW+2] == '0);
    assign ld_we        = !i_rst && (state == ST_IDLE) && i_ld_valid && ld_in_range;
    assign bus_we       = !i_rst && (state == ST_ACK) && !cap_rnw && cap_in_range;
    assign req_changed  = !i_valid || (i_rnw != cap_rnw) || (i_addr != cap_addr)
                          || (i_data != cap_data);
    assign unused_bits  = ^i_ld_addr[1:0];
    assign o_state      = state;

    // Contents survive reset; only the control path is cleared.
    always_ff @(posedge i_clk) begin
        if (ld_we) begin
            mem[i_ld_addr[AW+1:2]] <= i_ld_data;
        end else if (bus_we) begin
            mem[cap_addr[AW+1:2]] <= cap_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cap_rnw     <= 1'b0;
            cap_addr    <= '0;
            cap_data    <= '0;
            o_accept    <= 1'b0;
            o_data      <= '0;
            o_ld_ready  <= 1'b1;
            o_addr_err  <= 1'b0;
            o_proto_err <= 1'b0;
        end else begin
            o_accept <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_ld_valid) begin
                        o_ld_ready <= 1'b1;
                        if (!ld_in_range) o_addr_err <= 1'b1;
                    end else if (i_valid) begin
                        cap_rnw    <= i_rnw;
                        cap_addr   <= i_addr;
                        cap_data   <= i_data;
                        o_ld_ready <= 1'b0;
                        if (!bus_in_range) o_addr_err <= 1'b1;
                        if (WAIT == 0) begin
                            state    <= ST_ACK;
                            o_accept <= 1'b1;
                            if (i_rnw) o_data <= bus_in_range ? mem[i_addr[AW+1:2]] : '0;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_CNT;
                        end
                    end else begin
                        o_ld_ready <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (req_changed) o_proto_err <= 1'b1;
                    if (cnt <= 4'd1) begin
                        state    <= ST_ACK;
                        o_accept <= 1'b1;
                        cnt      <= '0;
                        if (cap_rnw) o_data <= cap_in_range ? mem[cap_addr[AW+1:2]] : '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    if (req_changed) o_proto_err <= 1'b1;
                    state      <= ST_IDLE;
                    o_ld_ready <= 1'b1;
                end
                default: begin
                    state      <= ST_IDLE;
                    o_ld_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
